hex_display_arbiter: RTL and testbench
======================================

// Module: hex_display_arbiter
// PURPOSE
//   Shares the single 2-digit hex byte display between NUM_REQ requesters.
//   Round-robin arbitration with a minimum hold (time slice) per grant.
//   Drives hex_byte into the display driver; owner index is available for a
//   status digit. Sits between debug/status sources and the display driver.
// PARAMETERS
//   NUM_REQ      4           number of requesters (2..8)
//   HOLD_CYCLES  50000000    minimum grant length in clk cycles (>=1); 0.5 s @ 100 MHz
//   IDX_W        $clog2(NUM_REQ)   localparam, owner index width
//   CNT_W        $clog2(HOLD_CYCLES+1)   localparam, hold counter width
// PORTS
//   clk        in   1            system clock, all logic on posedge
//   rst_n      in   1            asynchronous active-low reset
//   req        in   NUM_REQ      per-requester request, level
//   req_byte   in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//   grant      out  NUM_REQ      one-hot grant, registered
//   busy       out  1            1 while any grant is held
//   owner      out  IDX_W        index of current/last owner
//   hex_byte   out  8            byte to the display driver
// BEHAVIOUR
//   Reset (async, rst_n=0): grant=0, busy=0, owner=NUM_REQ-1, hex_byte=8'h00,
//     hold counter=0, state=IDLE. Effect is immediate, independent of clk.
//   States: IDLE, GRANT. busy == (state==GRANT); grant == busy ? onehot(owner) : 0.
//   Pick: first i with req[i]=1 searching owner+1, owner+2, ... modulo NUM_REQ
//     (owner itself is searched last).
//   IDLE: if |req at edge -> GRANT, owner=pick, counter=0, hex_byte=req_byte[pick].
//     Latency req->grant: 1 cycle. No req -> stay; hex_byte keeps last value.
//   GRANT: counter increments, saturating at HOLD_CYCLES-1 (hold_done).
//     hex_byte <= req_byte[owner] every cycle while req[owner]=1; frozen otherwise.
//     Before hold_done: grant never changes, even if req[owner] drops.
//     At/after hold_done, evaluated each edge:
//       other requester pending -> switch to pick directly (no IDLE bubble),
//         counter=0, hex_byte=req_byte[pick];
//       else req[owner]=1 -> stay, counter stays saturated;
//       else -> IDLE, grant=0 next edge; owner and hex_byte retained.
//   HOLD_CYCLES=1: hold_done on first grant cycle, i.e. per-cycle time slicing.
//   Simultaneous requests: resolved only by round-robin order above.
//   Request asserted and dropped inside one cycle with no edge: ignored.
//   req_byte of non-owners never reaches hex_byte.
//   All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//   Shared include hex_display_defs.vh: state encodings (ST_IDLE, ST_GRANT),
//     DEFAULT_HOLD_CYCLES, blank-byte constant 8'h00.
//   Sub-module hex_rr_picker (combinational): inputs req, base index;
//     outputs any, pick index. Top holds FSM, counter, registered outputs.
// TESTING  (NUM_REQ=4, HOLD_CYCLES=4)
//   1 rst_n=0 with req=4'hF -> grant=0, busy=0, owner=3, hex_byte=00; stays so
//     until rst_n=1, first grant=4'b0001 one edge after release.
//   2 req=4'b0100, byte2=A5 from IDLE -> next edge grant=4'b0100, owner=2,
//     hex_byte=A5; byte2 changes to 3C -> hex_byte=3C one edge later.
//   3 owner=2 last, req0 and req3 raised together -> grant 3 for 4 cycles,
//     then grant 0 on the next edge with no idle cycle; then grant 3 again.
//   4 owner req drops 1 cycle after grant, byte changes -> grant held to cycle 4,
//     hex_byte frozen at last sampled value, then grant=0, busy=0, owner kept.
//   5 single requester held 20 cycles, no competitors -> grant constant 20 cycles,
//     counter saturated; competitor raised -> switch on next edge.
//   6 rst_n pulsed low mid-GRANT between clock edges -> outputs cleared without
//     a clk edge; arbitration restarts from owner=3 (req0 highest priority).

Source files
------------

// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex byte display arbiter: FSM states and
// default constants.
package hex_display_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // 0.5 s at 100 MHz
    localparam int DEFAULT_HOLD_CYCLES = 50000000;
    localparam logic [7:0] BLANK_BYTE = 8'h00;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Requester/display bus of the hex display arbiter: per-requester level
// requests and bytes in, one-hot grant, owner and selected byte out.
interface hex_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][7:0]   req_byte;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic [IDX_W-1:0]          owner;
    logic [7:0]                hex_byte;

    modport master (
        output req, req_byte,
        input  grant, busy, owner, hex_byte
    );

    modport slave (
        input  req, req_byte,
        output grant, busy, owner, hex_byte
    );

endinterface

// File: rtl/hex_rr_picker.sv
// Combinational round-robin picker: first requester after base, wrapping,
// with base itself searched last.
module hex_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               any,
    output logic [IDX_W-1:0]   pick
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        any  = 1'b0;
        pick = base;
        cand = base;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(base) + k) % NUM_REQ);
            if (req[cand]) begin
                any  = 1'b1;
                pick = cand;
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the 2-digit hex display with a minimum time slice
// per grant; all outputs are registered.
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    hex_display_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] OWNER_RST  = IDX_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hex_q, hex_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDX_W-1:0]   pick;
    logic               any;
    logic               others;
    logic               hold_done;

    hex_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req  (bus.req),
        .base (owner_q),
        .any  (any),
        .pick (pick)
    );

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Owner is searched last, so whenever others is set the pick is a non-owner.
    assign others    = |(bus.req & ~owner_oh);
    assign hold_done = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    owner_d = pick;
                    cnt_d   = '0;
                    hex_d   = bus.req_byte[pick];
                end
            end
            ST_GRANT: begin
                if (!hold_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.req[owner_q])
                        hex_d = bus.req_byte[owner_q];
                end else if (others) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    hex_d   = bus.req_byte[pick];
                end else if (bus.req[owner_q]) begin
                    hex_d = bus.req_byte[owner_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d == ST_GRANT)
            grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_RST;
            cnt_q   <= '0;
            hex_q   <= BLANK_BYTE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q == ST_GRANT);
    assign bus.owner    = owner_q;
    assign bus.hex_byte = hex_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter (NUM_REQ=4, HOLD_CYCLES=4) with a
// cycle-level reference model checked every falling edge.
module tb_hex_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hex_display_arbiter_if #(.NUM_REQ(N)) bus ();

    hex_display_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        int         owner;
        int         age;     // cycles the current grant has been held
        logic [7:0] hex;
    } model_t;

    model_t m;

    function automatic int rr_pick(logic [N-1:0] r, int base);
        for (int k = 1; k <= N; k++) begin
            int idx = (base + k) % N;
            if (r[idx[1:0]]) return idx;
        end
        return base;
    endfunction

    function automatic model_t step(model_t c, logic [N-1:0] r, logic [N-1:0][7:0] b);
        model_t n = c;
        int p = rr_pick(r, c.owner);
        int others = 0;
        for (int i = 0; i < N; i++)
            if (r[i] && i != c.owner) others++;
        if (!c.busy) begin
            if (r != 0) begin
                n.busy = 1'b1; n.owner = p; n.age = 1; n.hex = b[p[1:0]];
            end
        end else if (c.age < HOLD) begin
            n.age = c.age + 1;
            if (r[c.owner[1:0]]) n.hex = b[c.owner[1:0]];
        end else if (others > 0) begin
            n.owner = p; n.age = 1; n.hex = b[p[1:0]];
        end else if (r[c.owner[1:0]]) begin
            n.hex = b[c.owner[1:0]];
        end else begin
            n.busy = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{busy: 1'b0, owner: N - 1, age: 0, hex: 8'h00};
        else        m <= step(m, bus.req, bus.req_byte);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_grant", 32'(bus.grant), m.busy ? (32'd1 << m.owner) : 32'd0);
        chk("model_busy",  32'(bus.busy),  32'(m.busy));
        chk("model_owner", 32'(bus.owner), 32'(m.owner));
        chk("model_hex",   32'(bus.hex_byte), 32'(m.hex));
    end

    task automatic wait_idle();
        bus.req = '0;
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),  32'd0);
        chk({tag, "_owner"}, 32'(bus.owner), 32'd3);
        chk({tag, "_hex"},   32'(bus.hex_byte), 32'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 4'hF;
        bus.req_byte[0] = 8'h11;
        bus.req_byte[1] = 8'h22;
        bus.req_byte[2] = 8'hA5;
        bus.req_byte[3] = 8'h44;

        // 1: reset holds with all requests pending; req0 wins first
        repeat (3) begin
            @(negedge clk);
            chk_reset("t1_rst");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_grant", 32'(bus.grant), 32'h1);
        chk("t1_owner", 32'(bus.owner), 32'd0);
        chk("t1_hex",   32'(bus.hex_byte), 32'h11);
        wait_idle();

        // 2: single request from IDLE, byte follows owner
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t2_grant", 32'(bus.grant), 32'b0100);
        chk("t2_owner", 32'(bus.owner), 32'd2);
        chk("t2_hex",   32'(bus.hex_byte), 32'hA5);
        bus.req_byte[2] = 8'h3C;
        @(negedge clk);
        chk("t2_hex2",  32'(bus.hex_byte), 32'h3C);
        wait_idle();

        // 3: req0 and req3 together after owner 2: 3, then 0, then 3
        bus.req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_g3", 32'(bus.grant), 32'b1000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_g0", 32'(bus.grant), 32'b0001);
        end
        @(negedge clk);
        chk("t3_g3b", 32'(bus.grant), 32'b1000);
        wait_idle();

        // 4: owner drops after one cycle; grant held for full slice, byte frozen
        bus.req_byte[1] = 8'h5A;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("t4_grant", 32'(bus.grant), 32'b0010);
        chk("t4_hex",   32'(bus.hex_byte), 32'h5A);
        bus.req = 4'b0000;
        bus.req_byte[1] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold", 32'(bus.grant), 32'b0010);
            chk("t4_frz",  32'(bus.hex_byte), 32'h5A);
        end
        @(negedge clk);
        chk("t4_rel_grant", 32'(bus.grant), 32'd0);
        chk("t4_rel_busy",  32'(bus.busy),  32'd0);
        chk("t4_rel_owner", 32'(bus.owner), 32'd1);
        chk("t4_rel_hex",   32'(bus.hex_byte), 32'h5A);

        // 5: long single owner, then competitor switches on next edge
        bus.req_byte[2] = 8'hB7;
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_hold", 32'(bus.grant), 32'b0100);
            bus.req_byte[2] = 8'(8'hB0 + i);
        end
        bus.req = 4'b0101;
        @(negedge clk);
        chk("t5_switch", 32'(bus.grant), 32'b0001);
        chk("t5_hex",    32'(bus.hex_byte), 32'h11);
        wait_idle();

        // 6: async reset between edges mid-grant; restart from owner 3
        bus.req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("t6_pre", 32'(bus.grant), 32'b0100);
        #2 rst_n = 1'b0;
        #1 chk_reset("t6_async");
        bus.req = 4'b0101;
        @(negedge clk);
        chk_reset("t6_held");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_grant", 32'(bus.grant), 32'b0001);
        chk("t6_owner", 32'(bus.owner), 32'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
